// File: rtl/riscv_cbm_sched.sv
// In-order scheduler sharing one bit-serial CBM multiplier between both issue lanes.
// Ops are queued in a small FIFO, dispatched one at a time, and each result is held until writeback.
module riscv_cbm_sched #(
    parameter int QUEUE_DEPTH = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lane0_valid_i,
    input  logic [DATA_W-1:0] lane0_ra_i,
    input  logic [DATA_W-1:0] lane0_rb_i,
    input  logic [4:0]        lane0_rd_idx_i,
    output logic              lane0_ready_o,
    input  logic              lane1_valid_i,
    input  logic [DATA_W-1:0] lane1_ra_i,
    input  logic [DATA_W-1:0] lane1_rb_i,
    input  logic [4:0]        lane1_rd_idx_i,
    output logic              lane1_ready_o,
    input  logic              flush_i,
    output logic              cbm_valid_o,
    output logic [DATA_W-1:0] cbm_ra_o,
    output logic [DATA_W-1:0] cbm_rb_o,
    output logic [4:0]        cbm_rd_idx_o,
    input  logic              cbm_busy_i,
    input  logic              cbm_result_valid_i,
    input  logic [DATA_W-1:0] cbm_result_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_idx_o,
    output logic [DATA_W-1:0] wb_value_o,
    input  logic              wb_accept_i,
    output logic [31:0]       pending_rd_o,
    output logic              idle_o
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_W-1:0]      r_ra_mem [QUEUE_DEPTH];
    logic [DATA_W-1:0]      r_rb_mem [QUEUE_DEPTH];
    logic [4:0]             r_rd_mem [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] r_vld;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;

    logic [4:0]             r_rd_q;
    logic                   r_wb_valid;
    logic [4:0]             r_wb_rd;
    logic [DATA_W-1:0]      r_wb_value;

    logic [CW-1:0]          w_free;
    logic                   w_lane0_ready;
    logic                   w_lane1_ready;
    logic                   w_push0;
    logic                   w_push1;
    logic [PW-1:0]          w_wr_ptr1;
    logic                   w_dispatch;
    logic                   w_wb_load;
    logic [31:0]            w_fifo_mask [QUEUE_DEPTH];
    logic [31:0]            w_fifo_pending;

    // Ready never counts the slot freed by a same-cycle pop, keeping it independent of dispatch.
    assign w_free        = CW'(QUEUE_DEPTH) - r_count;
    assign w_lane0_ready = !rst_i && !flush_i && (w_free >= CW'(1));
    assign w_lane1_ready = !rst_i && !flush_i && (w_free >= (lane0_valid_i ? CW'(2) : CW'(1)));

    assign w_push0   = lane0_valid_i && w_lane0_ready && (lane0_rd_idx_i != 5'd0);
    assign w_push1   = lane1_valid_i && w_lane1_ready && (lane1_rd_idx_i != 5'd0);
    assign w_wr_ptr1 = r_wr_ptr + PW'(w_push0);

    assign w_dispatch = !rst_i && !flush_i && (r_state == S_IDLE) && (r_count != '0)
                        && !cbm_busy_i && (!r_wb_valid || wb_accept_i);

    always_comb begin
        w_state_next = r_state;
        w_wb_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dispatch) w_state_next = S_BUSY;
            end
            S_BUSY: begin
                // A strobe coinciding with flush belongs to the squashed op.
                if (flush_i) begin
                    w_state_next = cbm_result_valid_i ? S_IDLE : S_DRAIN;
                end else if (cbm_result_valid_i) begin
                    w_state_next = S_IDLE;
                    w_wb_load    = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cbm_result_valid_i) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push0) begin
            r_ra_mem[r_wr_ptr] <= lane0_ra_i;
            r_rb_mem[r_wr_ptr] <= lane0_rb_i;
            r_rd_mem[r_wr_ptr] <= lane0_rd_idx_i;
        end
        if (w_push1) begin
            r_ra_mem[w_wr_ptr1] <= lane1_ra_i;
            r_rb_mem[w_wr_ptr1] <= lane1_rb_i;
            r_rd_mem[w_wr_ptr1] <= lane1_rd_idx_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_vld      <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_rd_q     <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_value <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush_i) begin
                r_vld    <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_dispatch) r_vld[r_rd_ptr] <= 1'b0;
                if (w_push0)    r_vld[r_wr_ptr] <= 1'b1;
                if (w_push1)    r_vld[w_wr_ptr1] <= 1'b1;
                r_rd_ptr <= r_rd_ptr + PW'(w_dispatch);
                r_wr_ptr <= r_wr_ptr + PW'(w_push0) + PW'(w_push1);
                r_count  <= r_count + CW'(w_push0) + CW'(w_push1) - CW'(w_dispatch);
            end
            if (w_dispatch) r_rd_q <= r_rd_mem[r_rd_ptr];
            if (w_wb_load) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd_q;
                r_wb_value <= cbm_result_i;
            end else if (wb_accept_i) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_fifo_mask
            assign w_fifo_mask[gi] = r_vld[gi] ? (32'd1 << r_rd_mem[gi]) : 32'd0;
        end
    endgenerate

    always_comb begin
        w_fifo_pending = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_fifo_pending = w_fifo_pending | w_fifo_mask[i];
        end
    end

    assign pending_rd_o = w_fifo_pending
                        | ((r_state == S_BUSY) ? (32'd1 << r_rd_q) : 32'd0)
                        | (r_wb_valid ? (32'd1 << r_wb_rd) : 32'd0);

    assign lane0_ready_o = w_lane0_ready;
    assign lane1_ready_o = w_lane1_ready;
    assign cbm_valid_o   = w_dispatch;
    assign cbm_ra_o      = w_dispatch ? r_ra_mem[r_rd_ptr] : '0;
    assign cbm_rb_o      = w_dispatch ? r_rb_mem[r_rd_ptr] : '0;
    assign cbm_rd_idx_o  = w_dispatch ? r_rd_mem[r_rd_ptr] : '0;
    assign wb_valid_o    = r_wb_valid;
    assign wb_rd_idx_o   = r_wb_rd;
    assign wb_value_o    = r_wb_value;
    assign idle_o        = !rst_i && (r_count == '0) && (r_state == S_IDLE) && !r_wb_valid;

endmodule

// File: tb/tb_riscv_cbm_sched.sv
// Bench for riscv_cbm_sched: behavioural multi-cycle CBM, dispatch/writeback scoreboard,
// a vector table for lane acceptance and hand-written multi-cycle sequences.
module tb_riscv_cbm_sched;

    localparam int CBM_LAT = 34;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lane0_valid_i, lane1_valid_i;
    logic [31:0] lane0_ra_i, lane0_rb_i, lane1_ra_i, lane1_rb_i;
    logic [4:0]  lane0_rd_idx_i, lane1_rd_idx_i;
    logic        flush_i, cbm_busy_i, cbm_result_valid_i, wb_accept_i;
    logic [31:0] cbm_result_i;
    logic        lane0_ready_o, lane1_ready_o, cbm_valid_o, wb_valid_o, idle_o;
    logic [31:0] cbm_ra_o, cbm_rb_o, wb_value_o, pending_rd_o;
    logic [4:0]  cbm_rd_idx_o, wb_rd_idx_o;

    riscv_cbm_sched #(.QUEUE_DEPTH(2), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lane0_valid_i(lane0_valid_i), .lane0_ra_i(lane0_ra_i), .lane0_rb_i(lane0_rb_i),
        .lane0_rd_idx_i(lane0_rd_idx_i), .lane0_ready_o(lane0_ready_o),
        .lane1_valid_i(lane1_valid_i), .lane1_ra_i(lane1_ra_i), .lane1_rb_i(lane1_rb_i),
        .lane1_rd_idx_i(lane1_rd_idx_i), .lane1_ready_o(lane1_ready_o),
        .flush_i(flush_i),
        .cbm_valid_o(cbm_valid_o), .cbm_ra_o(cbm_ra_o), .cbm_rb_o(cbm_rb_o), .cbm_rd_idx_o(cbm_rd_idx_o),
        .cbm_busy_i(cbm_busy_i), .cbm_result_valid_i(cbm_result_valid_i), .cbm_result_i(cbm_result_i),
        .wb_valid_o(wb_valid_o), .wb_rd_idx_o(wb_rd_idx_o), .wb_value_o(wb_value_o), .wb_accept_i(wb_accept_i),
        .pending_rd_o(pending_rd_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] ra; logic [31:0] rb; logic [4:0] rd; logic [31:0] v; } op_t;
    typedef struct { logic [4:0] rd; logic [31:0] v; } wb_t;
    typedef struct {
        logic l0v; logic [31:0] a0; logic [31:0] b0; logic [4:0] rd0; logic [31:0] v0;
        logic l1v; logic [31:0] a1; logic [31:0] b1; logic [4:0] rd1; logic [31:0] v1;
        logic rdy0; logic rdy1;
    } vec_t;

    op_t exp_disp[$];
    wb_t exp_wb[$];
    vec_t vecs[6];

    int n_checks = 0, n_fail = 0;
    int n_disp = 0, n_wb = 0, n_strobe = 0, cyc = 0;
    int last_disp_cyc = -1, last_acc_cyc = -2;
    bit inflight = 0;
    bit m_disp = 0, m_spur = 0;
    logic [31:0] m_ra, m_rb, m_prod;
    int m_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        op_t o;
        wb_t w;
        if (rst_i) begin
            exp_disp.delete();
            exp_wb.delete();
            inflight = 0;
            m_disp = 0;
            return;
        end
        m_disp = cbm_valid_o;
        m_ra   = cbm_ra_o;
        m_rb   = cbm_rb_o;
        if (cbm_valid_o) begin
            n_disp++;
            last_disp_cyc = cyc;
            $display("cyc %0d dispatch rd=%0d ra=%0h rb=%0h", cyc, cbm_rd_idx_o, cbm_ra_o, cbm_rb_o);
            if (exp_disp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dispatch: got rd %0d, expected no dispatch", cbm_rd_idx_o);
            end else begin
                o = exp_disp.pop_front();
                check("disp_ra", cbm_ra_o, o.ra);
                check("disp_rb", cbm_rb_o, o.rb);
                check("disp_rd", cbm_rd_idx_o, o.rd);
                w.rd = o.rd;
                w.v  = o.v;
                exp_wb.push_back(w);
                inflight = 1;
            end
        end
        if (wb_valid_o && wb_accept_i) begin
            n_wb++;
            last_acc_cyc = cyc;
            $display("cyc %0d writeback rd=%0d value=%0h", cyc, wb_rd_idx_o, wb_value_o);
            if (exp_wb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wb: got rd %0d, expected no writeback", wb_rd_idx_o);
            end else begin
                w = exp_wb.pop_front();
                check("wb_rd", wb_rd_idx_o, w.rd);
                check("wb_value", wb_value_o, w.v);
            end
        end
        if (flush_i) begin
            exp_disp.delete();
            if (inflight) begin
                w = exp_wb.pop_back();
                inflight = 0;
            end
        end
        if (cbm_result_valid_i) begin
            n_strobe++;
            inflight = 0;
        end
    endtask

    task automatic model_step();
        if (rst_i) begin
            m_cnt = 0;
            cbm_busy_i = 0;
            cbm_result_valid_i = 0;
        end else begin
            cbm_result_valid_i = 0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    cbm_busy_i = 0;
                    cbm_result_valid_i = 1;
                    cbm_result_i = m_prod;
                end
            end else if (m_disp) begin
                cbm_busy_i = 1;
                m_cnt = CBM_LAT;
                m_prod = m_ra * m_rb;
            end else if (m_spur) begin
                cbm_result_valid_i = 1;
                cbm_result_i = 32'hDEAD_BEEF;
            end
        end
        m_spur = 0;
    endtask

    task automatic tick();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        cyc++;
        model_step();
    endtask

    task automatic set_l0(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        lane0_valid_i = 1; lane0_ra_i = a; lane0_rb_i = b; lane0_rd_idx_i = rd;
    endtask

    task automatic set_l1(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        lane1_valid_i = 1; lane1_ra_i = a; lane1_rb_i = b; lane1_rd_idx_i = rd;
    endtask

    task automatic clr_lanes();
        lane0_valid_i = 0;
        lane1_valid_i = 0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                            input logic [31:0] v);
        op_t o;
        if (rd != 5'd0) begin
            o.ra = a; o.rb = b; o.rd = rd; o.v = v;
            exp_disp.push_back(o);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            tick();
            if (idle_o && exp_disp.size() == 0 && exp_wb.size() == 0 && m_cnt == 0 && !cbm_busy_i) break;
        end
        if (k == max_cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle_timeout: got busy after %0d cycles, expected idle", max_cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready0"}, lane0_ready_o, 0);
        check({tag, "_ready1"}, lane1_ready_o, 0);
        check({tag, "_cbm_valid"}, cbm_valid_o, 0);
        check({tag, "_wb_valid"}, wb_valid_o, 0);
        check({tag, "_pending"}, pending_rd_o, 0);
        check({tag, "_idle"}, idle_o, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, s0, k;
        rst_i = 0; flush_i = 0; wb_accept_i = 1;
        lane0_valid_i = 0; lane1_valid_i = 0;
        lane0_ra_i = 0; lane0_rb_i = 0; lane0_rd_idx_i = 0;
        lane1_ra_i = 0; lane1_rb_i = 0; lane1_rd_idx_i = 0;
        cbm_busy_i = 0; cbm_result_valid_i = 0; cbm_result_i = 0;

        vecs[0] = '{1, 32'd7, 32'd6, 5'd13, 32'd42, 0, 32'd0, 32'd0, 5'd0, 32'd0, 1, 1};
        vecs[1] = '{1, 32'd3, 32'd5, 5'd10, 32'd15, 1, 32'hFFFF_FFFF, 32'd2, 5'd11, 32'hFFFF_FFFE, 1, 1};
        vecs[2] = '{1, 32'd9, 32'd9, 5'd0, 32'd81, 1, 32'd4, 32'd4, 5'd5, 32'd16, 1, 1};
        vecs[3] = '{0, 32'd0, 32'd0, 5'd0, 32'd0, 1, 32'h0001_0000, 32'h0001_0000, 5'd31, 32'd0, 1, 1};
        vecs[4] = '{1, 32'd2, 32'd2, 5'd0, 32'd4, 1, 32'd3, 32'd3, 5'd0, 32'd9, 1, 1};
        vecs[5] = '{1, 32'h8000_0001, 32'd3, 5'd1, 32'h8000_0003, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'd1, 1, 1};

        // Reset: all outputs zero while rst_i is high, even with a lane request present.
        #1 rst_i = 1;
        set_l0(32'd1, 32'd1, 5'd5);
        #2 check_all_zero("reset");
        tick(); tick();
        rst_i = 0; clr_lanes();
        tick();
        check("post_reset_idle", idle_o, 1);

        // Single op: one dispatch, pending bit held until writeback taken.
        d0 = n_disp; w0 = n_wb;
        set_l0(32'd7, 32'd6, 5'd13); push_exp(32'd7, 32'd6, 5'd13, 32'd42);
        #2 check("t1_ready0", lane0_ready_o, 1);
        check("t1_ready1", lane1_ready_o, 1);
        tick(); clr_lanes(); tick();
        check("t1_dispatched", n_disp - d0, 1);
        check("t1_pending_busy", pending_rd_o, 32'h0000_2000);
        check("t1_idle_busy", idle_o, 0);
        wait_idle(100);
        check("t1_disp_once", n_disp - d0, 1);
        check("t1_wb_count", n_wb - w0, 1);
        check("t1_pending_clear", pending_rd_o, 0);

        // Table of lane request patterns, each applied to an empty scheduler.
        for (int i = 0; i < 6; i++) begin
            w0 = n_wb;
            if (vecs[i].l0v) set_l0(vecs[i].a0, vecs[i].b0, vecs[i].rd0);
            if (vecs[i].l1v) set_l1(vecs[i].a1, vecs[i].b1, vecs[i].rd1);
            if (vecs[i].l0v && vecs[i].rdy0) push_exp(vecs[i].a0, vecs[i].b0, vecs[i].rd0, vecs[i].v0);
            if (vecs[i].l1v && vecs[i].rdy1) push_exp(vecs[i].a1, vecs[i].b1, vecs[i].rd1, vecs[i].v1);
            #2 check($sformatf("vec%0d_ready0", i), lane0_ready_o, vecs[i].rdy0);
            check($sformatf("vec%0d_ready1", i), lane1_ready_o, vecs[i].rdy1);
            tick(); clr_lanes();
            wait_idle(200);
            check($sformatf("vec%0d_wb_count", i), n_wb - w0,
                  int'(vecs[i].l0v && vecs[i].rd0 != 0) + int'(vecs[i].l1v && vecs[i].rd1 != 0));
        end

        // Fill the FIFO behind a busy op, then probe readiness with one free slot.
        d0 = n_disp; w0 = n_wb;
        set_l0(32'd2, 32'd2, 5'd1); push_exp(32'd2, 32'd2, 5'd1, 32'd4);
        tick(); clr_lanes(); tick();
        set_l0(32'd3, 32'd3, 5'd2); set_l1(32'd4, 32'd4, 5'd3);
        push_exp(32'd3, 32'd3, 5'd2, 32'd9); push_exp(32'd4, 32'd4, 5'd3, 32'd16);
        tick(); clr_lanes();
        set_l0(32'd9, 32'd9, 5'd4);
        #2 check("t3_full_ready0", lane0_ready_o, 0);
        check("t3_full_ready1", lane1_ready_o, 0);
        check("t3_pending", pending_rd_o, 32'h0000_000E);
        clr_lanes();
        for (k = 0; k < 100 && n_disp - d0 < 2; k++) tick();
        check("t3_second_dispatch", n_disp - d0, 2);
        set_l0(32'd5, 32'd5, 5'd4); set_l1(32'd6, 32'd6, 5'd5);
        push_exp(32'd5, 32'd5, 5'd4, 32'd25);
        #2 check("t3_free1_ready0", lane0_ready_o, 1);
        check("t3_free1_ready1", lane1_ready_o, 0);
        tick(); clr_lanes();
        wait_idle(300);
        check("t3_wb_count", n_wb - w0, 4);

        // Writeback back-pressure stalls the next dispatch until the accept cycle.
        d0 = n_disp;
        wb_accept_i = 0;
        set_l0(32'd5, 32'd5, 5'd20); set_l1(32'd6, 32'd7, 5'd21);
        push_exp(32'd5, 32'd5, 5'd20, 32'd25); push_exp(32'd6, 32'd7, 5'd21, 32'd42);
        tick(); clr_lanes();
        for (k = 0; k < 100 && !wb_valid_o; k++) tick();
        for (int i = 0; i < 20; i++) begin
            check("t4_hold_valid", wb_valid_o, 1);
            check("t4_hold_value", wb_value_o, 32'd25);
            tick();
        end
        check("t4_stalled", n_disp - d0, 1);
        wb_accept_i = 1;
        tick();
        check("t4_disp_in_accept_cycle", last_disp_cyc, last_acc_cyc);
        check("t4_second_dispatch", n_disp - d0, 2);
        check("t4_wb_cleared", wb_valid_o, 0);
        wait_idle(100);

        // A held result survives a flush.
        wb_accept_i = 0;
        set_l0(32'd9, 32'd9, 5'd3); push_exp(32'd9, 32'd9, 5'd3, 32'd81);
        tick(); clr_lanes();
        for (k = 0; k < 100 && !wb_valid_o; k++) tick();
        flush_i = 1; tick(); flush_i = 0;
        check("t5b_wb_kept", wb_valid_o, 1);
        check("t5b_wb_value", wb_value_o, 32'd81);
        check("t5b_pending", pending_rd_o, 32'h0000_0008);
        wb_accept_i = 1;
        wait_idle(50);

        // Flush while busy with two queued ops: the in-flight result is dropped.
        d0 = n_disp; w0 = n_wb;
        set_l0(32'd2, 32'd3, 5'd7); push_exp(32'd2, 32'd3, 5'd7, 32'd6);
        tick(); clr_lanes(); tick();
        set_l0(32'd4, 32'd5, 5'd8); set_l1(32'd6, 32'd6, 5'd9);
        push_exp(32'd4, 32'd5, 5'd8, 32'd20); push_exp(32'd6, 32'd6, 5'd9, 32'd36);
        tick(); clr_lanes(); tick(); tick();
        check("t5_pending_before", pending_rd_o, 32'h0000_0380);
        flush_i = 1; set_l0(32'd1, 32'd1, 5'd12);
        #2 check("t5_flush_ready0", lane0_ready_o, 0);
        check("t5_flush_ready1", lane1_ready_o, 0);
        tick(); flush_i = 0; clr_lanes();
        check("t5_pending_after", pending_rd_o, 0);
        check("t5_not_idle_drain", idle_o, 0);
        s0 = n_strobe;
        for (k = 0; k < 60 && n_strobe == s0; k++) tick();
        check("t5_no_wb", wb_valid_o, 0);
        check("t5_idle", idle_o, 1);
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_more_disp", n_disp - d0, 1);
        check("t5_wb_count", n_wb - w0, 0);

        // Spurious strobe in IDLE is ignored.
        w0 = n_wb;
        m_spur = 1; tick(); tick();
        check("spur_no_wb", wb_valid_o, 0);
        check("spur_idle", idle_o, 1);

        // Asynchronous reset in the middle of a busy op.
        set_l0(32'd3, 32'd3, 5'd15); push_exp(32'd3, 32'd3, 5'd15, 32'd9);
        tick(); clr_lanes();
        for (int i = 0; i < 5; i++) tick();
        check("t6_pending_busy", pending_rd_o, 32'h0000_8000);
        rst_i = 1; set_l0(32'd1, 32'd1, 5'd16);
        #1 check_all_zero("t6_reset");
        exp_disp.delete(); exp_wb.delete(); inflight = 0;
        tick(); rst_i = 0; clr_lanes();
        tick();
        check("t6_idle_after", idle_o, 1);
        check("t6_pending_after", pending_rd_o, 0);
        w0 = n_wb;
        set_l0(32'd8, 32'd8, 5'd17); push_exp(32'd8, 32'd8, 5'd17, 32'd64);
        tick(); clr_lanes();
        wait_idle(100);
        check("t6_wb_after_reset", n_wb - w0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
